// File: rtl/trng_pkg.sv
// trng_pkg: constants and types shared by the TRNG framer and the
// downstream sample buffer's word detector.
//   HEADER_DEF / SYNC_DEF / IDLE_DEF : default frame words
//   em_state_t                       : emitter state encoding
package trng_pkg;

  localparam logic [31:0] HEADER_DEF = 32'h0000_0071;
  localparam logic [31:0] SYNC_DEF   = 32'h0280_f76b;
  localparam logic [31:0] IDLE_DEF   = 32'h0000_0000;

  typedef enum logic [2:0] {
    EM_IDLE = 3'd0,
    EM_HDR  = 3'd1,
    EM_SYNC = 3'd2,
    EM_PAY  = 3'd3,
    EM_GAP  = 3'd4
  } em_state_t;

endpackage

// File: rtl/trng_health.sv
// trng_health: repetition-count health test on the raw bit stream plus
// optional Von Neumann debias.
// Ports:
//   clk_trng, rstn  clock, async active-low reset
//   raw_bit         raw entropy bit
//   raw_valid       raw_bit valid this cycle
//   bit_ok          a debiased (or raw, VN_EN=0) bit is offered this cycle
//   bit_val         value of the offered bit
//   trip            run of identical raw bits just reached RCT_LIMIT
module trng_health #(
  parameter bit          VN_EN     = 1'b1,
  parameter int unsigned RCT_LIMIT = 31
) (
  input  logic clk_trng,
  input  logic rstn,
  input  logic raw_bit,
  input  logic raw_valid,
  output logic bit_ok,
  output logic bit_val,
  output logic trip
);

  localparam logic [7:0] RCT_LIM8 = RCT_LIMIT[7:0];

  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic       prev_bit;
  logic       phase;
  logic       first_bit;

  // A run count of zero means no raw bit has been seen since reset.
  always_comb begin
    run_next = run_cnt;
    if (raw_valid) begin
      if ((run_cnt == 8'd0) || (raw_bit != prev_bit)) begin
        run_next = 8'd1;
      end else if (run_cnt != 8'hFF) begin
        run_next = run_cnt + 8'd1;
      end
    end
  end

  // Fires only on the bit that reaches the limit, not on later bits of the
  // same run (matters when the counter saturates at the limit).
  assign trip = raw_valid && (run_next == RCT_LIM8) && (run_cnt != RCT_LIM8);

  always_ff @(posedge clk_trng or negedge rstn) begin
    if (!rstn) begin
      run_cnt  <= 8'd0;
      prev_bit <= 1'b0;
    end else if (raw_valid) begin
      run_cnt  <= run_next;
      prev_bit <= raw_bit;
    end
  end

  // Pair 10 -> 1, pair 01 -> 0: the output equals the first bit of the pair.
  always_ff @(posedge clk_trng or negedge rstn) begin
    if (!rstn) begin
      phase     <= 1'b0;
      first_bit <= 1'b0;
    end else if (trip) begin
      phase <= 1'b0;
    end else if (raw_valid) begin
      if (!phase) first_bit <= raw_bit;
      phase <= ~phase;
    end
  end

  always_comb begin
    if (VN_EN) begin
      bit_ok  = raw_valid && phase && (first_bit != raw_bit);
      bit_val = first_bit;
    end else begin
      bit_ok  = raw_valid;
      bit_val = raw_bit;
    end
  end

endmodule

// File: rtl/trng_framer.sv
// trng_framer: packs health-checked entropy bits into 32-bit words and
// emits each word as a HEADER, SYNC, PAYLOAD frame followed by idle gap.
// Ports:
//   clk_trng, rstn  clock, async active-low reset
//   en              frame enable, looked at only while idle
//   raw_bit         raw entropy bit
//   raw_valid       raw_bit valid this cycle
//   err_clr         pulse clearing health_err
//   data_O          framed word stream
//   frame_o         high on HEADER, SYNC and PAYLOAD cycles
//   health_err      sticky repetition-count failure
//   word_cnt        payload words emitted, wrapping
//
// Emitter states:
//   state   | meaning
//   EM_IDLE | stream idle, waiting for a held word and en
//   EM_HDR  | driving HEADER
//   EM_SYNC | driving SYNC
//   EM_PAY  | driving the held word, hold released
//   EM_GAP  | forced idle, gap_cnt counting down
module trng_framer
  import trng_pkg::*;
#(
  parameter bit          VN_EN      = 1'b1,
  parameter int unsigned RCT_LIMIT  = 31,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [31:0] HEADER     = HEADER_DEF,
  parameter logic [31:0] SYNC       = SYNC_DEF,
  parameter logic [31:0] IDLE       = IDLE_DEF
) (
  input  logic        clk_trng,
  input  logic        rstn,
  input  logic        en,
  input  logic        raw_bit,
  input  logic        raw_valid,
  input  logic        err_clr,
  output logic [31:0] data_O,
  output logic        frame_o,
  output logic        health_err,
  output logic [15:0] word_cnt
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic        bit_ok;
  logic        bit_val;
  logic        trip;
  logic        accept;
  logic [5:0]  bit_cnt;
  logic [31:0] shift_reg;
  logic [31:0] shift_next;
  logic [31:0] hold;
  logic        hold_valid;
  logic        hold_space;
  logic        hold_load;
  logic [31:0] hold_word;
  em_state_t   state;
  logic [3:0]  gap_cnt;

  trng_health #(
    .VN_EN     (VN_EN),
    .RCT_LIMIT (RCT_LIMIT)
  ) u_health (
    .clk_trng  (clk_trng),
    .rstn      (rstn),
    .raw_bit   (raw_bit),
    .raw_valid (raw_valid),
    .bit_ok    (bit_ok),
    .bit_val   (bit_val),
    .trip      (trip)
  );

  assign accept     = bit_ok && !health_err && !trip;
  assign shift_next = {shift_reg[30:0], bit_val};

  // Hold counts as free during the PAYLOAD cycle, so a word finishing on
  // that cycle moves straight in without a bubble.
  assign hold_space = !hold_valid || (state == EM_PAY);
  assign hold_load  = !trip && hold_space &&
                      ((bit_cnt == 6'd32) || (accept && (bit_cnt == 6'd31)));
  assign hold_word  = (bit_cnt == 6'd32) ? shift_reg : shift_next;

  always_ff @(posedge clk_trng or negedge rstn) begin
    if (!rstn) begin
      health_err <= 1'b0;
    end else if (trip) begin
      health_err <= 1'b1;
    end else if (err_clr) begin
      health_err <= 1'b0;
    end
  end

  // bit_cnt == 32 means a complete word is parked in shift_reg waiting for
  // hold; further accepted bits are dropped until it moves.
  always_ff @(posedge clk_trng or negedge rstn) begin
    if (!rstn) begin
      bit_cnt   <= 6'd0;
      shift_reg <= 32'd0;
    end else if (trip) begin
      bit_cnt <= 6'd0;
    end else if (bit_cnt == 6'd32) begin
      if (hold_space) bit_cnt <= 6'd0;
    end else if (accept) begin
      shift_reg <= shift_next;
      if (bit_cnt == 6'd31) begin
        bit_cnt <= hold_space ? 6'd0 : 6'd32;
      end else begin
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_trng or negedge rstn) begin
    if (!rstn) begin
      hold       <= 32'd0;
      hold_valid <= 1'b0;
    end else if (hold_load) begin
      hold       <= hold_word;
      hold_valid <= 1'b1;
    end else if (state == EM_PAY) begin
      hold_valid <= 1'b0;
    end
  end

  // Outputs are loaded together with the next state so they line up with
  // the state the FSM occupies.
  always_ff @(posedge clk_trng or negedge rstn) begin
    if (!rstn) begin
      state    <= EM_IDLE;
      gap_cnt  <= 4'd0;
      data_O   <= IDLE;
      frame_o  <= 1'b0;
      word_cnt <= 16'd0;
    end else begin
      case (state)
        EM_IDLE: begin
          if (hold_valid && en) begin
            state   <= EM_HDR;
            data_O  <= HEADER;
            frame_o <= 1'b1;
          end else begin
            data_O  <= IDLE;
            frame_o <= 1'b0;
          end
        end
        EM_HDR: begin
          state   <= EM_SYNC;
          data_O  <= SYNC;
          frame_o <= 1'b1;
        end
        EM_SYNC: begin
          state    <= EM_PAY;
          data_O   <= hold;
          frame_o  <= 1'b1;
          word_cnt <= word_cnt + 16'd1;
        end
        EM_PAY: begin
          state   <= EM_GAP;
          gap_cnt <= GAP_LOAD;
          data_O  <= IDLE;
          frame_o <= 1'b0;
        end
        EM_GAP: begin
          data_O  <= IDLE;
          frame_o <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state <= EM_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state   <= EM_IDLE;
          data_O  <= IDLE;
          frame_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_framer.sv
// tb_trng_framer: self-checking bench for trng_framer. Two instances share
// the stimulus: one passes raw bits through, one debiases.
module tb_trng_framer;

  localparam logic [31:0] HDR = 32'h0000_0071;
  localparam logic [31:0] SYN = 32'h0280_f76b;
  localparam logic [31:0] IDL = 32'h0000_0000;
  localparam int          RCT = 31;

  logic        clk_trng = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] data_raw, data_vn;
  logic        frame_raw, frame_vn;
  logic        err_raw, err_vn;
  logic [15:0] cnt_raw, cnt_vn;

  always #5 clk_trng = ~clk_trng;

  trng_framer #(.VN_EN(1'b0), .RCT_LIMIT(RCT), .GAP_CYCLES(2)) u_raw (
    .clk_trng(clk_trng), .rstn(rstn), .en(en), .raw_bit(raw_bit),
    .raw_valid(raw_valid), .err_clr(err_clr), .data_O(data_raw),
    .frame_o(frame_raw), .health_err(err_raw), .word_cnt(cnt_raw));

  trng_framer #(.VN_EN(1'b1), .RCT_LIMIT(RCT), .GAP_CYCLES(2)) u_vn (
    .clk_trng(clk_trng), .rstn(rstn), .en(en), .raw_bit(raw_bit),
    .raw_valid(raw_valid), .err_clr(err_clr), .data_O(data_vn),
    .frame_o(frame_vn), .health_err(err_vn), .word_cnt(cnt_vn));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Frame monitors: verify HEADER/SYNC framing and collect payloads.
  logic [31:0] pay_raw[$];
  logic [31:0] pay_vn[$];
  int pos_raw = 0;
  int pos_vn = 0;

  always @(negedge clk_trng) begin
    if (!rstn) pos_raw = 0;
    else if (frame_raw) begin
      if (pos_raw == 0) chk("raw_header", data_raw, HDR);
      else if (pos_raw == 1) chk("raw_sync", data_raw, SYN);
      else pay_raw.push_back(data_raw);
      pos_raw = (pos_raw == 2) ? 0 : pos_raw + 1;
    end else pos_raw = 0;
  end

  always @(negedge clk_trng) begin
    if (!rstn) pos_vn = 0;
    else if (frame_vn) begin
      if (pos_vn == 0) chk("vn_header", data_vn, HDR);
      else if (pos_vn == 1) chk("vn_sync", data_vn, SYN);
      else pay_vn.push_back(data_vn);
      pos_vn = (pos_vn == 2) ? 0 : pos_vn + 1;
    end else pos_vn = 0;
  end

  typedef struct {
    logic        en;
    logic [31:0] data;
    logic        frame;
  } vec_t;
  vec_t vecs [0:19];

  task automatic run_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      raw_valid = 1'b0;
      en = vecs[i].en;
      @(negedge clk_trng);
      chk($sformatf("%s_row%0d_data", tag, i), data_raw, vecs[i].data);
      chk($sformatf("%s_row%0d_frame", tag, i), 32'(frame_raw), 32'(vecs[i].frame));
    end
  endtask

  task automatic do_reset();
    en = 1'b0; raw_valid = 1'b0; err_clr = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk_trng);
    pay_raw.delete();
    pay_vn.delete();
    rstn = 1'b1;
    @(negedge clk_trng);
  endtask

  task automatic feed_bit(input logic b);
    raw_bit = b;
    raw_valid = 1'b1;
    @(negedge clk_trng);
    raw_valid = 1'b0;
  endtask

  task automatic feed_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      raw_bit = w[i];
      raw_valid = 1'b1;
      @(negedge clk_trng);
    end
    raw_valid = 1'b0;
  endtask

  task automatic wait_pay(input bit vn, input int n, input int budget, input string name);
    int k = 0;
    while (((vn ? pay_vn.size() : pay_raw.size()) < n) && (k < budget)) begin
      @(negedge clk_trng);
      k++;
    end
    chk(name, 32'(vn ? pay_vn.size() : pay_raw.size()), 32'(n));
  endtask

  // Reference model: turns the list of valid raw bits into the words the
  // framer must emit, straight from the health/debias/packing rules.
  logic        rnd_bits[$];
  logic [31:0] exp_q[$];

  function automatic void build_exp(input bit vn);
    int run = 0;
    int prev_run;
    logic prev = 1'b0;
    bit err = 1'b0;
    bit have = 1'b0;
    logic first = 1'b0;
    bit got;
    logic val;
    logic b;
    logic [31:0] acc = 32'd0;
    int n = 0;
    exp_q.delete();
    foreach (rnd_bits[k]) begin
      b = rnd_bits[k];
      prev_run = run;
      if (run == 0 || b != prev) run = 1;
      else if (run < 255) run++;
      prev = b;
      if (run == RCT && prev_run != RCT) begin
        err = 1'b1; n = 0; have = 1'b0;
        continue;
      end
      got = 1'b0;
      val = b;
      if (vn) begin
        if (!have) begin first = b; have = 1'b1; end
        else begin
          have = 1'b0;
          if (first != b) begin got = 1'b1; val = first; end
        end
      end else got = 1'b1;
      if (got && !err) begin
        acc = {acc[30:0], val};
        n++;
        if (n == 32) begin exp_q.push_back(acc); n = 0; end
      end
    end
  endfunction

  localparam logic [31:0] WORD_B = 32'h0F0F_0F0F;

  initial begin
    int hi_cnt;
    int k;

    vecs[0]  = '{1'b1, HDR, 1'b1};
    vecs[1]  = '{1'b1, SYN, 1'b1};
    vecs[2]  = '{1'b1, 32'h5555_5555, 1'b1};
    vecs[3]  = '{1'b1, IDL, 1'b0};
    vecs[4]  = '{1'b1, IDL, 1'b0};
    vecs[5]  = '{1'b1, IDL, 1'b0};
    vecs[6]  = '{1'b0, IDL, 1'b0};
    vecs[7]  = '{1'b0, IDL, 1'b0};
    vecs[8]  = '{1'b0, IDL, 1'b0};
    vecs[9]  = '{1'b1, HDR, 1'b1};
    vecs[10] = '{1'b1, SYN, 1'b1};
    vecs[11] = '{1'b0, 32'h3333_3333, 1'b1};
    vecs[12] = '{1'b0, IDL, 1'b0};
    vecs[13] = '{1'b0, IDL, 1'b0};
    vecs[14] = '{1'b0, IDL, 1'b0};
    vecs[15] = '{1'b1, IDL, 1'b0};
    vecs[16] = '{1'b1, IDL, 1'b0};
    vecs[17] = '{1'b1, HDR, 1'b1};
    vecs[18] = '{1'b1, SYN, 1'b1};
    vecs[19] = '{1'b1, WORD_B, 1'b1};

    // Reset values and the basic 0101 frame.
    do_reset();
    chk("rst_data_raw", data_raw, IDL);
    chk("rst_frame_raw", 32'(frame_raw), 32'd0);
    chk("rst_err_raw", 32'(err_raw), 32'd0);
    chk("rst_cnt_raw", 32'(cnt_raw), 32'd0);
    chk("rst_data_vn", data_vn, IDL);
    chk("rst_frame_vn", 32'(frame_vn), 32'd0);
    chk("rst_err_vn", 32'(err_vn), 32'd0);
    chk("rst_cnt_vn", 32'(cnt_vn), 32'd0);
    en = 1'b1;
    feed_word(32'h5555_5555);
    chk("t1_idle_after_fill", data_raw, IDL);
    run_rows(0, 5, "t1");
    chk("t1_word_cnt", 32'(cnt_raw), 32'd1);

    // Debias: 10/01 pairs with stray 00/11 pairs in between.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin feed_bit(1'b1); feed_bit(1'b0); end
      else begin feed_bit(1'b0); feed_bit(1'b1); end
      if ($urandom_range(0, 2) == 0) begin
        raw_bit = 1'($urandom_range(0, 1));
        feed_bit(raw_bit);
        feed_bit(raw_bit);
      end
    end
    wait_pay(1'b1, 1, 30, "t2_vn_pay_count");
    if (pay_vn.size() > 0) chk("t2_vn_payload", pay_vn[0], 32'hAAAA_AAAA);
    chk("t2_vn_word_cnt", 32'(cnt_vn), 32'd1);

    // Health test trip, partial discard, trip beating err_clr, restart.
    do_reset();
    en = 1'b1;
    repeat (30) feed_bit(1'b1);
    chk("t3_err_before_limit", 32'(err_raw), 32'd0);
    feed_bit(1'b1);
    chk("t3_err_raw_trip", 32'(err_raw), 32'd1);
    chk("t3_err_vn_trip", 32'(err_vn), 32'd1);
    repeat (30) feed_bit(1'b0);
    raw_bit = 1'b0; raw_valid = 1'b1; err_clr = 1'b1;
    @(negedge clk_trng);
    raw_valid = 1'b0; err_clr = 1'b0;
    chk("t3_trip_beats_clr", 32'(err_raw), 32'd1);
    for (int i = 0; i < 20; i++) feed_bit(1'(i % 2 == 0));
    repeat (6) @(negedge clk_trng);
    chk("t3_no_frame_while_err", 32'(pay_raw.size()), 32'd0);
    chk("t3_err_sticky", 32'(err_raw), 32'd1);
    err_clr = 1'b1;
    @(negedge clk_trng);
    err_clr = 1'b0;
    chk("t3_err_cleared", 32'(err_raw), 32'd0);
    feed_word(32'h5555_5555);
    wait_pay(1'b0, 1, 20, "t3_pay_count");
    if (pay_raw.size() > 0) chk("t3_payload_from_bit0", pay_raw[0], 32'h5555_5555);

    // en gating: word held while en=0, frame completes after en drops.
    do_reset();
    feed_word(32'h3333_3333);
    run_rows(6, 14, "t4");
    chk("t4_word_cnt", 32'(cnt_raw), 32'd1);

    // Second word completes on the PAYLOAD cycle of the first.
    do_reset();
    feed_word(32'h5555_5555);
    for (int i = 0; i < 32; i++) begin
      raw_bit = WORD_B[31-i];
      raw_valid = 1'b1;
      if (i == 28) en = 1'b1;
      @(negedge clk_trng);
    end
    raw_valid = 1'b0;
    chk("t5_gap_data", data_raw, IDL);
    chk("t5_gap_frame", 32'(frame_raw), 32'd0);
    if (pay_raw.size() > 0) chk("t5_first_payload", pay_raw[0], 32'h5555_5555);
    else chk("t5_first_payload_missing", 32'(pay_raw.size()), 32'd1);
    run_rows(15, 19, "t5");
    chk("t5_word_cnt", 32'(cnt_raw), 32'd2);

    // Reset asserted during SYNC.
    repeat (4) @(negedge clk_trng);
    en = 1'b1;
    feed_word(32'hF0F0_F0F0);
    k = 0;
    while (data_raw !== SYN && k < 12) begin
      @(negedge clk_trng);
      k++;
    end
    chk("t6_reached_sync", data_raw, SYN);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_data", data_raw, IDL);
    chk("t6_async_frame", 32'(frame_raw), 32'd0);
    chk("t6_async_cnt", 32'(cnt_raw), 32'd0);
    @(negedge clk_trng);
    pay_raw.delete();
    pay_vn.delete();
    rstn = 1'b1;
    hi_cnt = 0;
    repeat (12) begin
      @(negedge clk_trng);
      if (frame_raw) hi_cnt++;
    end
    chk("t6_no_partial_frame", 32'(hi_cnt), 32'd0);
    chk("t6_cnt_after", 32'(cnt_raw), 32'd0);

    // Random raw stream against the reference model.
    do_reset();
    en = 1'b1;
    rnd_bits.delete();
    for (int i = 0; i < 2500; i++) begin
      raw_valid = ($urandom_range(0, 3) != 0);
      raw_bit = 1'($urandom_range(0, 1));
      if (raw_valid) rnd_bits.push_back(raw_bit);
      @(negedge clk_trng);
    end
    raw_valid = 1'b0;

    build_exp(1'b0);
    wait_pay(1'b0, exp_q.size(), 100, "rnd_raw_count");
    for (int i = 0; i < exp_q.size() && i < pay_raw.size(); i++)
      chk($sformatf("rnd_raw_word%0d", i), pay_raw[i], exp_q[i]);
    chk("rnd_raw_word_cnt", 32'(cnt_raw), 32'(exp_q.size()));

    build_exp(1'b1);
    wait_pay(1'b1, exp_q.size(), 100, "rnd_vn_count");
    for (int i = 0; i < exp_q.size() && i < pay_vn.size(); i++)
      chk($sformatf("rnd_vn_word%0d", i), pay_vn[i], exp_q[i]);
    chk("rnd_vn_word_cnt", 32'(cnt_vn), 32'(exp_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
